// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing constants, counter widths and small decode helpers
// shared by the sync generator and its pixel divider.
package vga_timing_pkg;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // 100 MHz board clock down to the 25 MHz pixel rate
  localparam int unsigned PIX_CLK_DIV = 4;

  localparam int unsigned CNT_W       = 10;
  localparam int unsigned CNT_LIMIT   = 1 << CNT_W;
  localparam int unsigned FRAME_CNT_W = 16;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic video_on;
  } vga_level_t;

  // True while lo <= pos < lo+len; compared at 32 bits so lo+len may reach CNT_LIMIT.
  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input int unsigned      lo,
                                     input int unsigned      len);
    return (32'(pos) >= lo) && (32'(pos) < (lo + len));
  endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Clock divider producing a one-clk pixel enable every CLK_DIV cycles;
// the enable is suppressed while reset is asserted.
module pix_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic clk_rst,
  output logic pix_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             at_top;

  always_comb begin
    at_top    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    div_cnt_d = at_top ? '0 : div_cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clk_rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign pix_tick = at_top & ~clk_rst;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel enable, h/v counters, syncs, blanking and line/frame pulses.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame counter output frame_cnt.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = PIX_CLK_DIV,
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter bit          SYNC_POL  = SYNC_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             clk_rst,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             h_sync,
  output logic             v_sync,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int unsigned H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;

  localparam vga_level_t LEVELS_RST = '{h_sync: ~SYNC_POL, v_sync: ~SYNC_POL, video_on: 1'b0};

  if (H_TOT > CNT_LIMIT) begin : g_h_total_chk
    $error("vga_sync_gen: horizontal total exceeds counter range");
  end
  if (V_TOT > CNT_LIMIT) begin : g_v_total_chk
    $error("vga_sync_gen: vertical total exceeds counter range");
  end
  if (CLK_DIV < 1) begin : g_div_chk
    $error("vga_sync_gen: CLK_DIV must be at least 1");
  end

  logic             tick;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_wrap, v_wrap;
  logic             line_wrap, frame_wrap;
  vga_level_t       levels_q, levels_d;
  logic             line_start_q, frame_start_q;

  pix_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_div (
    .clk      (clk),
    .clk_rst  (clk_rst),
    .pix_tick (tick)
  );

  // Next raster position; levels decode from it so flags track the counters with no skew.
  always_comb begin
    h_wrap     = (h_cnt_q == CNT_W'(H_TOT - 1));
    v_wrap     = (v_cnt_q == CNT_W'(V_TOT - 1));
    line_wrap  = tick & h_wrap;
    frame_wrap = line_wrap & v_wrap;
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    if (tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + CNT_W'(1);
      end
    end
    levels_d.h_sync   = in_window(h_cnt_d, HS_START, H_SYNC) ? SYNC_POL : ~SYNC_POL;
    levels_d.v_sync   = in_window(v_cnt_d, VS_START, V_SYNC) ? SYNC_POL : ~SYNC_POL;
    levels_d.video_on = (h_cnt_d < CNT_W'(H_VISIBLE)) && (v_cnt_d < CNT_W'(V_VISIBLE));
  end

  // Levels load only on ticks so the post-reset (0,0) pixel stays blanked.
  always_ff @(posedge clk) begin
    if (clk_rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      levels_q      <= LEVELS_RST;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      if (tick) begin
        levels_q <= levels_d;
      end
      line_start_q  <= line_wrap;
      frame_start_q <= frame_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (clk_rst) begin
      frame_cnt_q <= '0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign pix_tick    = tick;
  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign h_sync      = levels_q.h_sync;
  assign v_sync      = levels_q.v_sync;
  assign video_on    = levels_q.video_on;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen on a shrunken raster; expected outputs come from
// an arithmetic model driven by the number of clocks since the last reset edge.
module tb_vga_sync_gen;

  localparam int unsigned D  = 4;
  localparam int unsigned HV = 20;
  localparam int unsigned HF = 3;
  localparam int unsigned HS = 5;
  localparam int unsigned HB = 4;
  localparam int unsigned VV = 12;
  localparam int unsigned VF = 2;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 3;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned LINE_CLK  = HT * D;
  localparam int unsigned FRAME_CLK = HT * VT * D;

  logic       clk = 1'b0;
  logic       clk_rst = 1'b1;
  logic       pix_tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_sync;
  logic       v_sync;
  logic       video_on;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int k        = 1;

  typedef struct packed {
    logic       tick;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ls;
    logic       fs;
  } obs_t;

  vga_sync_gen #(
    .CLK_DIV   (D),
    .H_VISIBLE (HV),
    .H_FRONT   (HF),
    .H_SYNC    (HS),
    .H_BACK    (HB),
    .V_VISIBLE (VV),
    .V_FRONT   (VF),
    .V_SYNC    (VS),
    .V_BACK    (VB),
    .SYNC_POL  (1'b0)
  ) dut (
    .clk         (clk),
    .clk_rst     (clk_rst),
    .pix_tick    (pix_tick),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .video_on    (video_on),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // kk = 1 is the cycle right after the last reset edge; ticks end every D-th cycle.
  function automatic obs_t model(input int kk, input logic rst_now);
    obs_t e;
    int   p, h, v;
    p = (kk - 1) / int'(D);
    h = p % int'(HT);
    v = (p / int'(HT)) % int'(VT);
    e.tick = !rst_now && ((kk % int'(D)) == 0);
    e.h    = 10'(h);
    e.v    = 10'(v);
    if (p == 0) begin
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.von = 1'b0;
    end else begin
      e.hs  = !((h >= int'(HV + HF)) && (h < int'(HV + HF + HS)));
      e.vs  = !((v >= int'(VV + VF)) && (v < int'(VV + VF + VS)));
      e.von = (h < int'(HV)) && (v < int'(VV));
    end
    e.ls = (kk > 1) && (((kk - 1) % int'(D)) == 0) && (h == 0);
    e.fs = e.ls && (v == 0);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.tick = pix_tick;
    o.h    = h_cnt;
    o.v    = v_cnt;
    o.hs   = h_sync;
    o.vs   = v_sync;
    o.von  = video_on;
    o.ls   = line_start;
    o.fs   = frame_start;
    return o;
  endfunction

  // One clock: reset level applied for the new cycle, then return at the falling edge.
  task automatic next_cycle(input logic rst_next);
    logic r;
    r = clk_rst;
    @(posedge clk);
    k = r ? 1 : k + 1;
    #1 clk_rst = rst_next;
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t e, o;
    int   first_tick;
    for (int i = 0; i < 10; i++) begin
      next_cycle(1'b1);
      e = model(k, clk_rst);
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_hold i=%0d got=%h exp=%h", i, o, e);
      end
      if (i == 9) begin
        checks++;
        if ({h_cnt, v_cnt, h_sync, v_sync, video_on, pix_tick} !== {10'd0, 10'd0, 4'b1100}) begin
          failures++;
          $display("FAIL reset_values got=%h/%h/%b%b%b%b exp=0/0/1100",
                   h_cnt, v_cnt, h_sync, v_sync, video_on, pix_tick);
        end
      end
    end
    first_tick = -1;
    for (int i = 1; i <= 2 * int'(D); i++) begin
      next_cycle(1'b0);
      e = model(k, clk_rst);
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_release k=%0d got=%h exp=%h", k, o, e);
      end
      if (pix_tick && first_tick < 0) first_tick = i;
      if (i == int'(D) + 1) begin
        checks++;
        if ({h_cnt, v_cnt, video_on} !== {10'd1, 10'd0, 1'b1}) begin
          failures++;
          $display("FAIL first_pixel got=(%0d,%0d) von=%b exp=(1,0) von=1", h_cnt, v_cnt, video_on);
        end
      end
    end
    checks++;
    if (first_tick != int'(D)) begin
      failures++;
      $display("FAIL first_tick got=%0d exp=%0d", first_tick, D);
    end
  endtask

  task automatic test_horizontal();
    obs_t e, o;
    int   hs_fall, last_ls, last_tick;
    logic hs_prev, von_prev;
    hs_fall   = -1;
    last_ls   = -1;
    last_tick = -1;
    hs_prev   = h_sync;
    von_prev  = video_on;
    for (int i = 0; i < 2 * int'(LINE_CLK); i++) begin
      next_cycle(1'b0);
      e = model(k, clk_rst);
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL hline k=%0d got=%h exp=%h", k, o, e);
      end
      if (hs_prev && !h_sync) begin
        hs_fall = i;
        checks++;
        if (h_cnt !== 10'(HV + HF)) begin
          failures++;
          $display("FAIL hsync_start got=%0d exp=%0d", h_cnt, HV + HF);
        end
      end
      if (!hs_prev && h_sync && hs_fall >= 0) begin
        checks++;
        if (i - hs_fall != int'(HS * D)) begin
          failures++;
          $display("FAIL hsync_width got=%0d exp=%0d", i - hs_fall, HS * D);
        end
      end
      if (von_prev && !video_on) begin
        checks++;
        if (h_cnt !== 10'(HV)) begin
          failures++;
          $display("FAIL video_off_col got=%0d exp=%0d", h_cnt, HV);
        end
      end
      if (line_start) begin
        if (last_ls >= 0) begin
          checks++;
          if (i - last_ls != int'(LINE_CLK)) begin
            failures++;
            $display("FAIL line_period got=%0d exp=%0d", i - last_ls, LINE_CLK);
          end
        end
        last_ls = i;
      end
      if (pix_tick) begin
        if (last_tick >= 0) begin
          checks++;
          if (i - last_tick != int'(D)) begin
            failures++;
            $display("FAIL tick_period got=%0d exp=%0d", i - last_tick, D);
          end
        end
        last_tick = i;
      end
      hs_prev  = h_sync;
      von_prev = video_on;
    end
  endtask

  task automatic test_vertical();
    obs_t e, o;
    logic found;
    int   vis, hsl, fs_cnt, vs_clk;
    found = 1'b0;
    for (int i = 0; i < int'(FRAME_CLK + LINE_CLK) && !found; i++) begin
      next_cycle(1'b0);
      e = model(k, clk_rst);
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL frame_seek k=%0d got=%h exp=%h", k, o, e);
      end
      if (frame_start) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL frame_start_timeout got=none exp=pulse within %0d clk", FRAME_CLK + LINE_CLK);
    end
    vis    = 0;
    hsl    = 0;
    fs_cnt = 0;
    vs_clk = 0;
    for (int i = 0; i <= int'(FRAME_CLK); i++) begin
      if (i > 0) begin
        next_cycle(1'b0);
        e = model(k, clk_rst);
        o = sample();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL frame_run k=%0d got=%h exp=%h", k, o, e);
        end
      end
      if (i < int'(FRAME_CLK)) begin
        if (video_on && pix_tick) vis++;
        if (!h_sync && pix_tick) hsl++;
        if (frame_start) fs_cnt++;
        if (!v_sync) vs_clk++;
      end else begin
        checks++;
        if ({frame_start, h_cnt, v_cnt} !== {1'b1, 10'd0, 10'd0}) begin
          failures++;
          $display("FAIL frame_period fs=%b pos=(%0d,%0d) exp fs=1 pos=(0,0)", frame_start, h_cnt, v_cnt);
        end
      end
    end
    checks++;
    if (vis != int'(HV * VV)) begin
      failures++;
      $display("FAIL visible_ticks got=%0d exp=%0d", vis, HV * VV);
    end
    checks++;
    if (hsl != int'(HS * VT)) begin
      failures++;
      $display("FAIL hsync_ticks got=%0d exp=%0d", hsl, HS * VT);
    end
    checks++;
    if (fs_cnt != 1) begin
      failures++;
      $display("FAIL frame_start_count got=%0d exp=1", fs_cnt);
    end
    checks++;
    if (vs_clk != int'(VS * LINE_CLK)) begin
      failures++;
      $display("FAIL vsync_width got=%0d exp=%0d", vs_clk, VS * LINE_CLK);
    end
  endtask

  task automatic test_mid_reset();
    obs_t e, o;
    logic found;
    int   run;
    for (int t = 0; t < 4; t++) begin
      found = 1'b0;
      // Pass 0 is directed into the h_sync pulse of a visible line; others land at random.
      run = (t == 0) ? int'(FRAME_CLK + LINE_CLK) : int'($urandom_range(1, FRAME_CLK));
      for (int i = 0; i < run && !found; i++) begin
        next_cycle(1'b0);
        e = model(k, clk_rst);
        o = sample();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL pre_reset t=%0d k=%0d got=%h exp=%h", t, k, o, e);
        end
        if (t == 0 && h_cnt == 10'(HV + HF + 2) && v_cnt == 10'd7) found = 1'b1;
      end
      if (t == 0) begin
        checks++;
        if (!found || h_sync !== 1'b0) begin
          failures++;
          $display("FAIL mid_reset_setup found=%b h_sync=%b exp found=1 h_sync=0", found, h_sync);
        end
      end
      next_cycle(1'b1);
      e = model(k, clk_rst);
      o = sample();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_cycle t=%0d got=%h exp=%h", t, o, e);
      end
      next_cycle(1'b0);
      checks++;
      if ({h_cnt, v_cnt, h_sync, v_sync, video_on, line_start, frame_start} !== {10'd0, 10'd0, 5'b11000}) begin
        failures++;
        $display("FAIL mid_reset_values t=%0d got=(%0d,%0d) %b%b%b%b%b exp=(0,0) 11000",
                 t, h_cnt, v_cnt, h_sync, v_sync, video_on, line_start, frame_start);
      end
      for (int i = 0; i < int'(LINE_CLK + 2 * D); i++) begin
        e = model(k, clk_rst);
        o = sample();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL restart t=%0d k=%0d got=%h exp=%h", t, k, o, e);
        end
        next_cycle(1'b0);
      end
    end
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt();
    obs_t        e, o;
    logic [15:0] fc_exp;
    int          steps;
    next_cycle(1'b1);
    next_cycle(1'b0);
    steps = 0;
    for (int i = 0; i < int'(3 * FRAME_CLK + LINE_CLK); i++) begin
      e = model(k, clk_rst);
      o = sample();
      fc_exp = 16'((((k - 1) / int'(D)) / int'(HT * VT)) % 65536);
      checks++;
      if (o !== e || frame_cnt !== fc_exp) begin
        failures++;
        $display("FAIL frame_cnt k=%0d got=%h/%0d exp=%h/%0d", k, o, frame_cnt, e, fc_exp);
      end
      if (frame_start) steps++;
      next_cycle(1'b0);
    end
    checks++;
    if (steps != 3 || frame_cnt !== 16'd3) begin
      failures++;
      $display("FAIL frame_cnt_steps got=%0d/%0d exp=3/3", steps, frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_mid_reset();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
